// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port owner: ALU/load-return arbitration, load scoreboard, r15 redirect.
// Optional WB_BYPASS_EN adds same-cycle write-to-read operand forwarding.
module reg_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int WIDTH        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_we,
  input  logic [3:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_wd,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  logic [3:0]       ld_issue_rd,
  input  logic             ld_valid,
  input  logic [3:0]       ld_rd,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  input  logic             use1,
  input  logic             use2,
  output logic             stall,
`ifdef WB_BYPASS_EN
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
`endif
  output logic             we3,
  output logic [3:0]       ra3,
  output logic [WIDTH-1:0] wd3,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_wd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [3:0]       f_rd   [DEPTH];
  logic [WIDTH-1:0] f_data [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;
  logic [15:0]      busy;
  logic [15:0]      busy_nxt;

  logic             full;
  logic             nempty;
  logic             push;
  logic             pop;
  logic             alu_win;
  logic             wr;
  logic [3:0]       sel_rd;
  logic [WIDTH-1:0] sel_wd;
  logic             hz;

  assign full    = (count == CW'(DEPTH));
  assign nempty  = (count != '0);
  assign ld_ready = !reset && !full;
  assign push    = ld_valid && ld_ready;

  // An empty FIFO can never starve, so the ALU always wins then.
  assign alu_win = !reset && alu_we &&
                   ((starve < SW'(STARVE_LIMIT)) || !nempty);
  assign pop       = !reset && nempty && !alu_win;
  assign alu_ready = !reset && (!alu_we || alu_win);

  assign wr     = alu_win || pop;
  assign sel_rd = pop ? f_rd[rptr] : alu_rd;
  assign sel_wd = pop ? f_data[rptr] : alu_wd;

  assign we3   = wr && (sel_rd != 4'd15);
  assign ra3   = sel_rd;
  assign wd3   = sel_wd;
  assign pc_we = wr && (sel_rd == 4'd15);
  assign pc_wd = sel_wd;

  always_comb begin
    hz = (use1 && busy[ra1]) ||
         (use2 && busy[ra2]) ||
         (ld_issue && busy[ld_issue_rd]);
`ifndef WB_BYPASS_EN
    hz = hz || (we3 && ((use1 && ra3 == ra1) ||
                        (use2 && ra3 == ra2)));
`endif
  end

  assign stall = !reset && hz;

`ifdef WB_BYPASS_EN
  assign op1 = (we3 && ra3 == ra1) ? wd3 : rf_rd1;
  assign op2 = (we3 && ra3 == ra2) ? wd3 : rf_rd2;
`endif

  // Set after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (pop)
      busy_nxt[f_rd[rptr]] = 1'b0;
    if (ld_issue && ld_issue_rd != 4'd15)
      busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[15] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      starve <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_nxt;
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || !nempty)
        starve <= '0;
      else if (alu_win && starve < SW'(STARVE_LIMIT))
        starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_rd[wptr]   <= ld_rd;
      f_data[wptr] <= ld_data;
    end
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Single owner of the register file write port (we3/ra3/wd3); register file is a 15-entry, 32-bit array with r15 supplied as PC+8.
- Merges same-cycle ALU results with out-of-order-completing load returns, the latter buffered in a small FIFO.
- Keeps a pending-load scoreboard and raises a stall for RAW/WAW hazards against decode-stage read addresses.
- Routes writes to r15 to the PC path, never to the array.

Parameters:
- DEPTH, 4, load-return FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to the ALU before it is forced to win
- WIDTH, 32, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- alu_we  in  1  ALU result valid
- alu_rd  in  4  ALU destination
- alu_wd  in  WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- ld_issue  in  1  load issued this cycle
- ld_issue_rd  in  4  issued load destination
- ld_valid  in  1  load data returning
- ld_rd  in  4  returning load destination
- ld_data  in  WIDTH  returning load data
- ld_ready  out  1  FIFO can accept a return
- ra1, ra2  in  4  decode read addresses
- use1, use2  in  1  read address is live
- stall  out  1  decode must hold
- we3  out  1  register file write enable
- ra3  out  4  register file write address
- wd3  out  WIDTH  register file write data
- pc_we  out  1  r15 write strobe
- pc_wd  out  WIDTH  r15 write data

Behaviour:
- Reset (sync, high): FIFO empty, busy[14:0]=0, starve counter=0. While reset is high: we3=0, pc_we=0, ld_ready=0, alu_ready=0, stall=0. A load in flight is discarded; its return is dropped unless it arrives after reset deasserts.
- ld_ready = !full, derived from registered count only. A push occurs on ld_valid && ld_ready. Push and pop in the same cycle are legal at any occupancy below full. At full, ld_ready=0 even if a pop occurs that cycle.
- Arbitration, one write per cycle:
  - The ALU wins if alu_we && starve counter < STARVE_LIMIT; alu_ready=1.
  - Otherwise a non-empty FIFO pops its head; alu_ready=0 when alu_we. The ALU holds alu_rd/alu_wd until alu_ready=1.
  - alu_ready=1 whenever alu_we=0.
- Starve counter: increments when the FIFO is non-empty and the ALU wins. Resets to 0 on any pop or when the FIFO is empty. Saturates at STARVE_LIMIT.
- Latency:
  - ALU write is combinational: we3/ra3/wd3 are driven in the same cycle and the array updates at the next edge.
  - A load return reaches the port no earlier than the cycle after its push, since the FIFO has no bypass.
- Selected write with rd==15: pc_we=1, pc_wd=data, we3=0. Otherwise we3=1, ra3=rd, wd3=data.
- Scoreboard:
  - ld_issue sets busy[ld_issue_rd]; issue to r15 sets nothing.
  - A pop clears busy[rd].
  - Same-cycle set and clear of the same register: set wins.
- stall = (use1 && busy[ra1]) || (use2 && busy[ra2]) || (ld_issue && busy[ld_issue_rd]), the last term being WAW.
  - busy is registered, so stall has no combinational path from ld_valid.
  - r15 is never busy.
- A return whose rd is not busy is still written, and busy stays 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Extra ports rf_rd1, rf_rd2 (in, WIDTH) and op1, op2 (out, WIDTH).
  - op1 = wd3 when we3 && ra3==ra1, else rf_rd1; op2 likewise with ra2 and rf_rd2.
  - Same-cycle write/read never stalls.
- Undefined:
  - No extra ports.
  - stall additionally asserts when we3 && use1 && ra3==ra1, or we3 && use2 && ra3==ra2.

Test Plan:
- Reset, then alu_we=1, alu_rd=3, alu_wd=0xDEADBEEF -> same cycle we3=1, ra3=3, wd3=0xDEADBEEF, alu_ready=1.
- ld_issue rd=5; next cycle ra1=5, use1=1 -> stall=1. Return ld_rd=5, data=0x1234 with ALU idle -> we3 with ra3=5 one cycle after push, busy[5] clear and stall=0 the following cycle.
- FIFO holds one entry; alu_we held high for 5 cycles -> ALU wins 3 cycles, cycle 4 alu_ready=0 and FIFO pops, cycle 5 ALU wins again.
- Push 4 returns with no pop (ALU busy, STARVE_LIMIT raised to 8) -> ld_ready=0 after the 4th push. A 5th ld_valid is not accepted and no entry is overwritten.
- alu_rd=15, alu_wd=0x100 -> pc_we=1, pc_wd=0x100, we3=0.
- Issue load rd=2, assert reset mid-flight, then deassert -> busy cleared, stall=0 with ra1=2, FIFO empty, ld_ready=1.
